// File: rtl/flit_arbiter_4x1_pkg.sv
// Shared definitions for the 4:1 flit arbiter: flit type codes, FSM state
// encoding and small helpers that classify a flit by its type field.
package flit_arbiter_4x1_pkg;

  localparam int unsigned num_ports = 4;

  // Flit type lives in the two MSBs of every flit.
  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // A head or single flit may start a packet and is an arbitration candidate.
  function automatic logic opens_packet(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

  // A tail or single flit ends the packet and releases the wormhole lock.
  function automatic logic closes_packet(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_SINGLE);
  endfunction

endpackage

// File: rtl/flit_arbiter_4x1_if.sv
// Bundle of the four input flit streams, the mux select and the buffered
// output link. The slave modport is the arbiter's view; master is the view of
// whatever drives the inputs and sinks the output.
interface flit_arbiter_4x1_if #(
  parameter int unsigned flit_width = 6
);

  logic [flit_width-1:0] flit1;
  logic [flit_width-1:0] flit2;
  logic [flit_width-1:0] flit3;
  logic [flit_width-1:0] flit4;
  logic [3:0]            in_valid;
  logic [3:0]            in_ready;
  logic [1:0]            select;
  logic [flit_width-1:0] out_flit;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  flit1,
    input  flit2,
    input  flit3,
    input  flit4,
    input  in_valid,
    output in_ready,
    output select,
    output out_flit,
    output out_valid,
    input  out_ready
  );

  modport master (
    output flit1,
    output flit2,
    output flit3,
    output flit4,
    output in_valid,
    input  in_ready,
    input  select,
    input  out_flit,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/flit_arbiter_4x1_rr_pick_4.sv
// Combinational round-robin picker: scans ptr, ptr+1, ... (mod 4) and returns
// the first requesting input. any=0 means nobody requested; grant is then 0.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // Walk the search order backwards so the last hit written is the first in
  // round-robin order; 2-bit addition gives the wrap 3 -> 0 for free.
  always_comb begin
    grant = 2'd0;
    any   = 1'b0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_flit_4x1.sv
// Plain 4:1 flit multiplexer steered by the arbiter's registered select.
module mux_flit_4x1 #(
  parameter int unsigned flit_width = 6
) (
  input  logic [flit_width-1:0] flit1,
  input  logic [flit_width-1:0] flit2,
  input  logic [flit_width-1:0] flit3,
  input  logic [flit_width-1:0] flit4,
  input  logic [1:0]            select,
  output logic [flit_width-1:0] out_flit
);

  // Route the selected input flit to the output.
  always_comb begin
    out_flit = flit1;
    unique case (select)
      2'd0: out_flit = flit1;
      2'd1: out_flit = flit2;
      2'd2: out_flit = flit3;
      2'd3: out_flit = flit4;
    endcase
  end

endmodule

// File: rtl/flit_arbiter_4x1.sv
// Wormhole round-robin arbiter for four flit inputs onto one output link.
// In IDLE it picks a head/single flit owner, then stays LOCKED on that input
// until the tail (or single) flit has been moved into the one-entry output
// buffer. The buffer may drain and refill in the same cycle.
module flit_arbiter_4x1
  import flit_arbiter_4x1_pkg::*;
#(
  parameter int unsigned flit_width = 6
) (
  input logic               clk,
  input logic               rst,
  flit_arbiter_4x1_if.slave bus
);

  arb_state_e            state_q;
  logic [1:0]            rr_ptr_q;
  logic [1:0]            select_q;
  logic [flit_width-1:0] out_flit_q;
  logic                  out_valid_q;

  logic [flit_width-1:0] muxed_flit;
  logic [3:0]            candidates;
  logic [1:0]            pick;
  logic                  pick_any;
  logic                  space;
  logic [3:0]            in_ready;
  logic                  xfer;

  function automatic logic [1:0] ftype(input logic [flit_width-1:0] f);
    return f[flit_width-1 -: 2];
  endfunction

  mux_flit_4x1 #(
    .flit_width(flit_width)
  ) u_mux (
    .flit1   (bus.flit1),
    .flit2   (bus.flit2),
    .flit3   (bus.flit3),
    .flit4   (bus.flit4),
    .select  (select_q),
    .out_flit(muxed_flit)
  );

  // Only valid head/single flits may open a packet; stray body/tail flits
  // sitting at an input while IDLE are ignored and never acknowledged.
  always_comb begin
    candidates    = '0;
    candidates[0] = bus.in_valid[0] & opens_packet(ftype(bus.flit1));
    candidates[1] = bus.in_valid[1] & opens_packet(ftype(bus.flit2));
    candidates[2] = bus.in_valid[2] & opens_packet(ftype(bus.flit3));
    candidates[3] = bus.in_valid[3] & opens_packet(ftype(bus.flit4));
  end

  rr_pick_4 u_pick (
    .req  (candidates),
    .ptr  (rr_ptr_q),
    .grant(pick),
    .any  (pick_any)
  );

  // Buffer can take a flit if empty or being drained this very cycle.
  assign space = ~out_valid_q | bus.out_ready;

  // Acknowledge only the locked owner, and only when the buffer has room.
  always_comb begin
    in_ready = '0;
    if (state_q == LOCKED) begin
      in_ready[select_q] = bus.in_valid[select_q] & space;
    end
  end

  assign xfer = |in_ready;

  // Arbitration FSM, round-robin pointer and the output buffer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      select_q    <= 2'd0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        out_flit_q  <= muxed_flit;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            select_q <= pick;
            state_q  <= LOCKED;
          end
        end
        LOCKED: begin
          // select_q keeps pointing at the last owner until the next grant.
          if (xfer && closes_packet(ftype(muxed_flit))) begin
            state_q  <= IDLE;
            rr_ptr_q <= select_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.select    = select_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_flit_arbiter_4x1.sv
// Self-checking bench for flit_arbiter_4x1: directed scenarios plus a long
// randomized run compared cycle by cycle against a behavioural model.
module tb_flit_arbiter_4x1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  flit_arbiter_4x1_if #(.flit_width(6)) bus ();

  flit_arbiter_4x1 #(
    .flit_width(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [5:0] q [4][$];
  int n_cmp = 0;
  int n_bad = 0;
  bit junk_en = 1'b0;

  // Present queue heads on the masked inputs, then settle just after negedge.
  task automatic drive(input logic [3:0] vmask, input logic ordy);
    logic [5:0] f [4];
    logic [3:0] v;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v[i] = vmask[i] && (q[i].size() > 0);
      if (v[i]) f[i] = q[i][0];
      else f[i] = junk_en ? 6'($urandom) : 6'd0;
    end
    bus.flit1 = f[0];
    bus.flit2 = f[1];
    bus.flit3 = f[2];
    bus.flit4 = f[3];
    bus.in_valid = v;
    bus.out_ready = ordy;
    #1;
  endtask

  // Source side: drop a flit from its queue once handshaken.
  task automatic pop_acked();
    for (int i = 0; i < 4; i++)
      if (bus.in_ready[i] && bus.in_valid[i] && q[i].size() > 0) void'(q[i].pop_front());
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 4'b0;
    bus.out_ready = 1'b0;
    bus.flit1 = '0;
    bus.flit2 = '0;
    bus.flit3 = '0;
    bus.flit4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.flit1 = 6'b010001;
    bus.flit2 = 6'b010010;
    bus.flit3 = 6'b010011;
    bus.flit4 = 6'b010100;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) @(posedge clk);
      if (k == 2) begin
        @(negedge clk);
        rst = 1'b0;
      end
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset[%0d].out_valid got %b want 0", k, bus.out_valid);
      end
      n_cmp++;
      if (bus.select !== 2'd0) begin
        n_bad++; $display("FAIL reset[%0d].select got %0d want 0", k, bus.select);
      end
      n_cmp++;
      if (bus.in_ready !== 4'b0) begin
        n_bad++; $display("FAIL reset[%0d].in_ready got %b want 0000", k, bus.in_ready);
      end
    end
    // First arbitration after release starts from input 0.
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.select !== 2'd0 || bus.in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset.first_grant got sel=%0d rdy=%b want sel=0 rdy=0001",
               bus.select, bus.in_ready);
    end
  endtask

  task automatic test_single_packet();
    logic [5:0] pk [3] = '{6'b010101, 6'b001010, 6'b100110};
    apply_reset();
    for (int k = 0; k < 3; k++) q[2].push_back(pk[k]);
    drive(4'b0100, 1'b1);
    n_cmp++;
    if (bus.in_ready !== 4'b0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single.arb_cycle got rdy=%b ov=%b want 0000/0", bus.in_ready,
                        bus.out_valid);
    end
    pop_acked();
    drive(4'b0100, 1'b1);
    n_cmp++;
    if (bus.select !== 2'd2 || bus.in_ready !== 4'b0100) begin
      n_bad++; $display("FAIL single.grant got sel=%0d rdy=%b want 2/0100", bus.select,
                        bus.in_ready);
    end
    pop_acked();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_flit !== pk[k]) begin
        n_bad++; $display("FAIL single.out[%0d] got v=%b %b want 1 %b", k, bus.out_valid,
                          bus.out_flit, pk[k]);
      end
      pop_acked();
    end
    n_cmp++;
    if (bus.in_ready !== 4'b0 || bus.select !== 2'd2) begin
      n_bad++; $display("FAIL single.idle_after_tail got rdy=%b sel=%0d want 0000/2",
                        bus.in_ready, bus.select);
    end
    // rr_ptr is now 3: input 3 beats input 0, afterwards the pointer wraps to 0.
    q[0].push_back(6'b110001);
    q[1].push_back(6'b110010);
    q[3].push_back(6'b110011);
    drive(4'b1001, 1'b1);
    pop_acked();
    drive(4'b1001, 1'b1);
    n_cmp++;
    if (bus.select !== 2'd3 || bus.in_ready !== 4'b1000) begin
      n_bad++; $display("FAIL single.rr_ptr3 got sel=%0d rdy=%b want 3/1000", bus.select,
                        bus.in_ready);
    end
    pop_acked();
    drive(4'b0011, 1'b1);
    n_cmp++;
    if (bus.out_flit !== 6'b110011 || bus.in_ready !== 4'b0) begin
      n_bad++; $display("FAIL single.out_s3 got %b rdy=%b want 110011/0000", bus.out_flit,
                        bus.in_ready);
    end
    pop_acked();
    drive(4'b0011, 1'b1);
    n_cmp++;
    if (bus.select !== 2'd0 || bus.in_ready !== 4'b0001) begin
      n_bad++; $display("FAIL single.wrap got sel=%0d rdy=%b want 0/0001", bus.select,
                        bus.in_ready);
    end
    pop_acked();
  endtask

  task automatic test_round_robin();
    int n;
    logic [5:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) q[i].push_back({2'b11, 2'(i), 2'(j)});
    for (int c = 0; c < 11; c++) begin
      drive(4'b1111, 1'b1);
      n = c / 2;
      if (c % 2 == 1) begin
        n_cmp++;
        if (bus.select !== 2'(n % 4) || bus.in_ready !== 4'(1 << (n % 4))) begin
          n_bad++; $display("FAIL rr.grant[%0d] got sel=%0d rdy=%b want %0d", n, bus.select,
                            bus.in_ready, n % 4);
        end
      end else begin
        n_cmp++;
        if (bus.in_ready !== 4'b0) begin
          n_bad++; $display("FAIL rr.gap[%0d] got rdy=%b want 0000", n, bus.in_ready);
        end
        if (c >= 2) begin
          e = {2'b11, 2'((n - 1) % 4), 2'((n - 1) / 4)};
          n_cmp++;
          if (bus.out_valid !== 1'b1 || bus.out_flit !== e) begin
            n_bad++; $display("FAIL rr.out[%0d] got v=%b %b want 1 %b", n - 1, bus.out_valid,
                              bus.out_flit, e);
          end
        end
      end
      pop_acked();
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] pk [5] = '{6'b010001, 6'b000010, 6'b000011, 6'b000100, 6'b100101};
    logic [5:0] got [$];
    logic ordy;
    apply_reset();
    for (int k = 0; k < 5; k++) q[1].push_back(pk[k]);
    for (int c = 0; c < 12; c++) begin
      ordy = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      drive(4'b0010, ordy);
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_flit !== pk[1] || bus.in_ready !== 4'b0) begin
          n_bad++; $display("FAIL bp.hold[%0d] got v=%b %b rdy=%b want 1 %b 0000", c,
                            bus.out_valid, bus.out_flit, bus.in_ready, pk[1]);
        end
      end
      if (bus.out_valid && ordy) got.push_back(bus.out_flit);
      pop_acked();
    end
    n_cmp++;
    if (got.size() != 5) begin
      n_bad++; $display("FAIL bp.count got %0d flits want 5", got.size());
    end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      n_cmp++;
      if (got[k] !== pk[k]) begin
        n_bad++; $display("FAIL bp.seq[%0d] got %b want %b", k, got[k], pk[k]);
      end
    end
  endtask

  task automatic test_wormhole();
    apply_reset();
    q[0].push_back(6'b010000);
    q[0].push_back(6'b000001);
    q[0].push_back(6'b000010);
    q[0].push_back(6'b100011);
    q[1].push_back(6'b010100);
    q[1].push_back(6'b100101);
    for (int c = 0; c < 7; c++) begin
      drive(4'b0011, 1'b1);
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if (bus.select !== 2'd0 || bus.in_ready !== 4'b0001) begin
          n_bad++; $display("FAIL worm.locked[%0d] got sel=%0d rdy=%b want 0/0001", c,
                            bus.select, bus.in_ready);
        end
      end else if (c == 5) begin
        n_cmp++;
        if (bus.select !== 2'd0 || bus.in_ready !== 4'b0) begin
          n_bad++; $display("FAIL worm.gap got sel=%0d rdy=%b want 0/0000", bus.select,
                            bus.in_ready);
        end
      end else if (c == 6) begin
        n_cmp++;
        if (bus.select !== 2'd1 || bus.in_ready !== 4'b0010) begin
          n_bad++; $display("FAIL worm.next got sel=%0d rdy=%b want 1/0010", bus.select,
                            bus.in_ready);
        end
      end
      pop_acked();
    end
  endtask

  task automatic test_protocol_guard();
    apply_reset();
    q[2].push_back(6'b001111);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1'b1);
      n_cmp++;
      if (bus.in_ready !== 4'b0 || bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL guard.body[%0d] got rdy=%b ov=%b want 0000/0", c, bus.in_ready,
                          bus.out_valid);
      end
      pop_acked();
    end
    q[2].delete();
    q[0].push_back(6'b010110);
    q[0].push_back(6'b000111);
    q[0].push_back(6'b001000);
    q[0].push_back(6'b101001);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001, 1'b1);
      pop_acked();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL guard.midpkt got ov=%b want 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0 || bus.select !== 2'd0) begin
      n_bad++; $display("FAIL guard.async_rst got ov=%b rdy=%b sel=%0d want 0/0000/0",
                        bus.out_valid, bus.in_ready, bus.select);
    end
    for (int i = 0; i < 4; i++) q[i].delete();
    q[0].push_back(6'b001010);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(4'b0001, 1'b1);
      n_cmp++;
      if (bus.in_ready !== 4'b0 || bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL guard.after_rst[%0d] got rdy=%b ov=%b want 0000/0", c,
                          bus.in_ready, bus.out_valid);
      end
      pop_acked();
    end
  endtask

  task automatic gen_packet(input int i);
    int len;
    len = $urandom_range(1, 4);
    if (len == 1) begin
      q[i].push_back({2'b11, 4'($urandom)});
    end else begin
      q[i].push_back({2'b01, 4'($urandom)});
      for (int k = 0; k < len - 2; k++) q[i].push_back({2'b00, 4'($urandom)});
      q[i].push_back({2'b10, 4'($urandom)});
    end
  endtask

  // Model: owner is the input holding the packet lock (-1 when free), rr the
  // input searched first at the next arbitration, m_* the output buffer.
  task automatic test_random();
    int owner, rr, idx;
    bit found;
    logic [1:0] m_sel;
    logic m_ov, ordy, space;
    logic [5:0] m_of;
    logic [5:0] f [4];
    logic [3:0] v, vm, exp_rdy;
    apply_reset();
    junk_en = 1'b1;
    owner = -1;
    rr = 0;
    m_sel = 2'd0;
    m_ov = 1'b0;
    m_of = 6'd0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0) gen_packet(i);
        vm[i] = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive(vm, ordy);
      f[0] = bus.flit1;
      f[1] = bus.flit2;
      f[2] = bus.flit3;
      f[3] = bus.flit4;
      v = bus.in_valid;
      space = !m_ov || ordy;
      exp_rdy = 4'b0;
      if (owner >= 0 && v[owner] && space) exp_rdy[owner] = 1'b1;
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rand.in_ready c=%0d got %b want %b", c, bus.in_ready, exp_rdy);
      end
      n_cmp++;
      if (bus.select !== m_sel) begin
        n_bad++; $display("FAIL rand.select c=%0d got %0d want %0d", c, bus.select, m_sel);
      end
      n_cmp++;
      if (bus.out_valid !== m_ov) begin
        n_bad++; $display("FAIL rand.out_valid c=%0d got %b want %b", c, bus.out_valid, m_ov);
      end
      n_cmp++;
      if (bus.out_flit !== m_of) begin
        n_bad++; $display("FAIL rand.out_flit c=%0d got %b want %b", c, bus.out_flit, m_of);
      end
      if (owner < 0) begin
        if (ordy) m_ov = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          idx = (rr + k) % 4;
          if (!found && v[idx] && (f[idx][5:4] == 2'b01 || f[idx][5:4] == 2'b11)) begin
            found = 1'b1;
            owner = idx;
            m_sel = 2'(idx);
          end
        end
      end else if (exp_rdy != 4'b0) begin
        m_of = f[owner];
        m_ov = 1'b1;
        if (f[owner][5]) begin
          rr = (owner + 1) % 4;
          owner = -1;
        end
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      pop_acked();
    end
    junk_en = 1'b0;
  endtask

  initial begin
    bus.flit1 = '0;
    bus.flit2 = '0;
    bus.flit3 = '0;
    bus.flit4 = '0;
    bus.in_valid = 4'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_wormhole();
    test_protocol_guard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
